stv_sync_fifo_core: RTL and testbench
=====================================

Name: stv_sync_fifo_core

Overview:
Parameterised single-clock ready/valid FIFO used as the storage primitive for buffers and FIFOs across the design. DEPTH=1 serves as a one-entry pipeline buffer; larger depths serve as general queues. Two options trade latency for timing: FLOW adds an empty-FIFO bypass, and SKID cuts the ready path from dout_ready to din_ready. Status outputs report empty, full and occupancy.

Parameters:
data_t, logic [7:0], payload type carried per entry.
DEPTH, 8, number of storage entries; must be >= 1.
FLOW, 1'b0, 1 = combinational bypass from din to dout when empty; 0 = minimum one-cycle latency.
SKID, 1'b0, 1 = no push while full, even if popping in the same cycle (removes the dout_ready->din_ready path).
CNTWIDTH (localparam), $clog2(DEPTH+1), width of count.

Ports:
clk  input  1  clock; all state updates on the rising edge.
arst_n  input  1  reset, synchronous, active-low.
clear  input  1  synchronous flush; empties the FIFO.
din_valid  input  1  push request.
din_ready  output  1  FIFO accepts din this cycle.
din  input  data_t  push data.
dout_valid  output  1  dout holds valid data.
dout_ready  input  1  consumer accepts dout.
dout  output  data_t  head-of-queue data.
empty  output  1  no stored entries.
full  output  1  DEPTH stored entries.
count  output  CNTWIDTH  number of stored entries, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries with write and read pointers that wrap DEPTH-1 -> 0, plus an occupancy counter. The array is not reset; pointers and counter are.
- Reset (arst_n=0 at a clock edge): pointers=0, count=0, empty=1, full=0, dout_valid=0 (FLOW=1: dout_valid follows din_valid). dout contents are don't-care.
- clear=1: same effect as reset on the next edge. Overrides any push or pop in that cycle. Handshake outputs still evaluate normally during the clear cycle.
- Status: empty = (count==0); full = (count==DEPTH). Status reflects stored entries only, never bypass data.
- push = din_valid && din_ready. pop = dout_valid && dout_ready.
- din_ready:
  - SKID=0: !full || dout_ready (push allowed when full if popping in the same cycle).
  - SKID=1: !full.
- FLOW=0:
  - dout_valid = !empty; dout = mem[rd_ptr].
  - Data written at edge N is first visible on dout after edge N.
- FLOW=1 and empty:
  - dout_valid = din_valid; dout = din.
  - If dout_ready=1, the word passes through without being stored (count stays 0).
  - Otherwise it is stored if din_ready=1.
- FLOW=1 and not empty: behaves exactly as FLOW=0.
- Counter update: count += push_stored - pop_stored.
  - push_stored excludes bypassed words.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- Ordering: strict FIFO; no data loss or duplication under any handshake pattern.
- Boundaries:
  - Full + pop + push (SKID=0): count stays DEPTH; the new word lands in the freed slot.
  - Empty + pop without valid: no effect.
- Upstream obligation: once din_valid is asserted with din_ready=0, din_valid and din hold until accepted.

Optional Feature:
STV_ASSERT_EN. When defined, simulation-only checks are compiled in, all disabled while arst_n=0:
- Elaboration: DEPTH >= 1, else $fatal.
- din_valid && !din_ready && !clear implies din_valid is still 1 next cycle, else $fatal "Valid unstable".
- Same antecedent implies din is stable next cycle, else $fatal "Data unstable".
- count never exceeds DEPTH.
When undefined, no checking logic is present and functional behaviour is identical.

Test Plan:
- DEPTH=4, FLOW=0, SKID=0: push 0x11,0x22,0x33,0x44 with dout_ready=0 -> count 1,2,3,4, then full=1, din_ready=0; then pop four -> dout 0x11..0x44 in order, empty=1, count=0.
- DEPTH=4 full, SKID=0: din_valid=1 din=0x55 with dout_ready=1 -> din_ready=1, pops 0x11, count stays 4; SKID=1, same stimulus -> din_ready=0, count becomes 3.
- FLOW=1, empty, din_valid=1 din=0xA5, dout_ready=1 -> dout_valid=1, dout=0xA5 the same cycle, count stays 0; FLOW=0, same stimulus -> dout_valid=0 that cycle, 0xA5 appears next cycle.
- DEPTH=1 (buffer use): stream of 8 words with dout_ready held at 1 -> one word accepted per cycle when SKID=0, one word every other cycle when SKID=1; output order preserved.
- Push 3 words into DEPTH=4, assert clear with push+pop active -> next cycle count=0, empty=1, dout_valid=0; the words pushed during the clear cycle are discarded.
- Random valid/ready, 1000 words, DEPTH=5 (pointer wrap) -> output sequence equals input sequence; count matches a scoreboard at every cycle.

Source files
------------

// File: rtl/stv_sync_fifo_core_if.sv
`default_nettype none
// ============================================================================
// Module      : stv_sync_fifo_core_if
// Description : Ready/valid push and pop handshake bundle for the sync FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface stv_sync_fifo_core_if #(
    parameter type data_t = logic [7:0]
);
    logic  din_valid;
    logic  din_ready;
    data_t din;
    logic  dout_valid;
    logic  dout_ready;
    data_t dout;

    // Producer/consumer environment side
    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );

    // FIFO side
    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );
endinterface
`default_nettype wire

// File: rtl/stv_sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : stv_sync_fifo_core
// Description : Single-clock ready/valid FIFO with optional empty bypass (FLOW)
//               and registered-style ready path (SKID). Define STV_ASSERT_EN to
//               compile in simulation-only protocol checks.
// Revision    : 1.0 - initial release
// ============================================================================
module stv_sync_fifo_core #(
    parameter type data_t   = logic [7:0],
    parameter int  DEPTH    = 8,
    parameter bit  FLOW     = 1'b0,
    parameter bit  SKID     = 1'b0,
    localparam int CNTWIDTH = $clog2(DEPTH + 1)
) (
    input  wire logic                clk,
    input  wire logic                arst_n,
    input  wire logic                clear,
    stv_sync_fifo_core_if.slave      bus,
    output logic                     empty,
    output logic                     full,
    output logic [CNTWIDTH-1:0]      count
);
    localparam int                  PTRWIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRWIDTH-1:0] LAST_PTR  = PTRWIDTH'(DEPTH - 1);
    localparam logic [CNTWIDTH-1:0] DEPTH_CNT = CNTWIDTH'(DEPTH);

    data_t               mem [DEPTH];
    logic [PTRWIDTH-1:0] wr_ptr;
    logic [PTRWIDTH-1:0] rd_ptr;
    logic                push;
    logic                pop;
    logic                push_stored;
    logic                pop_stored;
    logic                bypass;
    data_t               head;

    function automatic logic [PTRWIDTH-1:0] next_ptr(input logic [PTRWIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign head  = mem[rd_ptr];

    if (SKID) begin : g_skid
        assign bus.din_ready = !full;
    end else begin : g_noskid
        assign bus.din_ready = !full || bus.dout_ready;
    end

    // An empty FLOW FIFO presents din directly; a consumed word never touches storage.
    if (FLOW) begin : g_flow
        assign bypass         = empty && bus.dout_ready;
        assign bus.dout_valid = empty ? bus.din_valid : 1'b1;
        assign bus.dout       = empty ? bus.din : head;
    end else begin : g_noflow
        assign bypass         = 1'b0;
        assign bus.dout_valid = !empty;
        assign bus.dout       = head;
    end

    assign push        = bus.din_valid && bus.din_ready;
    assign pop         = bus.dout_valid && bus.dout_ready;
    assign push_stored = push && !bypass;
    assign pop_stored  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_stored) wr_ptr <= next_ptr(wr_ptr);
            if (pop_stored)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_stored, pop_stored})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n && !clear && push_stored) mem[wr_ptr] <= bus.din;
    end

`ifdef STV_ASSERT_EN
    if (DEPTH < 1) begin : g_depth_check
        $fatal(1, "DEPTH must be >= 1");
    end

    a_valid_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (bus.din_valid && !bus.din_ready && !clear) |=> bus.din_valid)
        else $fatal(1, "Valid unstable");

    a_data_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (bus.din_valid && !bus.din_ready && !clear) |=> $stable(bus.din))
        else $fatal(1, "Data unstable");

    a_count_range : assert property (@(posedge clk) disable iff (!arst_n)
        count <= DEPTH_CNT)
        else $fatal(1, "count exceeds DEPTH");
`endif
endmodule
`default_nettype wire

// File: tb/tb_stv_sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stv_sync_fifo_core
// Description : Directed and scoreboarded checks of stv_sync_fifo_core variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stv_sync_fifo_core;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic no_clr = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Group A stimulus drives the three DEPTH=4 variants together
    logic       g_vld = 1'b0, g_rdy = 1'b0, g_clr = 1'b0;
    logic [7:0] g_din = 8'h00;
    logic       d_vld = 1'b0, e_vld = 1'b0, d_rdy = 1'b0;
    logic [7:0] d_din = 8'h00, e_din = 8'h00;
    logic       f_vld = 1'b0, f_rdy = 1'b0;
    logic [7:0] f_din = 8'h00;

    stv_sync_fifo_core_if if_a ();
    stv_sync_fifo_core_if if_b ();
    stv_sync_fifo_core_if if_c ();
    stv_sync_fifo_core_if if_d ();
    stv_sync_fifo_core_if if_e ();
    stv_sync_fifo_core_if if_f ();

    assign if_a.din_valid = g_vld; assign if_a.din = g_din; assign if_a.dout_ready = g_rdy;
    assign if_b.din_valid = g_vld; assign if_b.din = g_din; assign if_b.dout_ready = g_rdy;
    assign if_c.din_valid = g_vld; assign if_c.din = g_din; assign if_c.dout_ready = g_rdy;
    assign if_d.din_valid = d_vld; assign if_d.din = d_din; assign if_d.dout_ready = d_rdy;
    assign if_e.din_valid = e_vld; assign if_e.din = e_din; assign if_e.dout_ready = d_rdy;
    assign if_f.din_valid = f_vld; assign if_f.din = f_din; assign if_f.dout_ready = f_rdy;

    logic       a_empty, a_full, b_empty, b_full, c_empty, c_full;
    logic       d_empty, d_full, e_empty, e_full, f_empty, f_full;
    logic [2:0] a_cnt, b_cnt, c_cnt, f_cnt;
    logic [0:0] d_cnt, e_cnt;

    stv_sync_fifo_core #(.DEPTH(4), .FLOW(1'b0), .SKID(1'b0)) u_a (
        .clk(clk), .arst_n(arst_n), .clear(g_clr), .bus(if_a.slave),
        .empty(a_empty), .full(a_full), .count(a_cnt));
    stv_sync_fifo_core #(.DEPTH(4), .FLOW(1'b0), .SKID(1'b1)) u_b (
        .clk(clk), .arst_n(arst_n), .clear(g_clr), .bus(if_b.slave),
        .empty(b_empty), .full(b_full), .count(b_cnt));
    stv_sync_fifo_core #(.DEPTH(4), .FLOW(1'b1), .SKID(1'b0)) u_c (
        .clk(clk), .arst_n(arst_n), .clear(g_clr), .bus(if_c.slave),
        .empty(c_empty), .full(c_full), .count(c_cnt));
    stv_sync_fifo_core #(.DEPTH(1), .FLOW(1'b0), .SKID(1'b0)) u_d (
        .clk(clk), .arst_n(arst_n), .clear(no_clr), .bus(if_d.slave),
        .empty(d_empty), .full(d_full), .count(d_cnt));
    stv_sync_fifo_core #(.DEPTH(1), .FLOW(1'b0), .SKID(1'b1)) u_e (
        .clk(clk), .arst_n(arst_n), .clear(no_clr), .bus(if_e.slave),
        .empty(e_empty), .full(e_full), .count(e_cnt));
    stv_sync_fifo_core #(.DEPTH(5), .FLOW(1'b0), .SKID(1'b0)) u_f (
        .clk(clk), .arst_n(arst_n), .clear(no_clr), .bus(if_f.slave),
        .empty(f_empty), .full(f_full), .count(f_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_a [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] fill  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] sb [$];
    int  di, ei, od, oe, sent, rcvd;
    logic acc_d, acc_e, pend, exp_rdy, do_pop, do_push;

    initial begin
        tick();
        tick();
        check("rst_count", a_cnt, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_dout_valid", if_a.dout_valid, 0);
        check("rst_flow_dout_valid", if_c.dout_valid, 0);
        arst_n = 1'b1;
        tick();

        // Empty FIFO: FLOW bypasses the word, FLOW=0 shows it one cycle later
        g_vld = 1'b1; g_din = 8'hA5; g_rdy = 1'b1;
        #1;
        check("flow_dout_valid", if_c.dout_valid, 1);
        check("flow_dout", if_c.dout, 8'hA5);
        check("noflow_dout_valid", if_a.dout_valid, 0);
        tick();
        check("flow_count", c_cnt, 0);
        check("noflow_count", a_cnt, 1);
        check("noflow_late_valid", if_a.dout_valid, 1);
        check("noflow_late_dout", if_a.dout, 8'hA5);
        g_vld = 1'b0;
        tick();
        check("drain_count", a_cnt, 0);
        check("empty_pop_noeffect", c_cnt, 0);

        // Fill DEPTH=4 with dout_ready low
        g_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g_vld = 1'b1; g_din = fill[i];
            tick();
            check("fill_count", a_cnt, i + 1);
        end
        g_vld = 1'b0;
        #1;
        check("full_a", a_full, 1);
        check("full_din_ready", if_a.din_ready, 0);
        check("full_b", b_full, 1);
        check("full_c_count", c_cnt, 4);
        check("full_head", if_a.dout, 8'h11);

        // Full + pop + push: SKID=0 accepts, SKID=1 refuses
        g_vld = 1'b1; g_din = 8'h55; g_rdy = 1'b1;
        #1;
        check("skid0_din_ready", if_a.din_ready, 1);
        check("skid1_din_ready", if_b.din_ready, 0);
        check("skid1_head", if_b.dout, 8'h11);
        tick();
        check("skid0_count", a_cnt, 4);
        check("skid1_count", b_cnt, 3);
        check("flow_full_count", c_cnt, 4);
        g_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("pop_valid", if_a.dout_valid, 1);
            check("pop_a", if_a.dout, exp_a[i]);
            check("pop_c", if_c.dout, exp_a[i]);
            if (i < 3) check("pop_b", if_b.dout, exp_a[i]);
            tick();
        end
        check("drained_empty", a_empty, 1);
        check("drained_count", a_cnt, 0);
        check("drained_b_count", b_cnt, 0);

        // Clear with push and pop active in the same cycle
        g_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            g_vld = 1'b1; g_din = 8'(i);
            tick();
        end
        check("pre_clear_count", a_cnt, 3);
        g_vld = 1'b1; g_din = 8'h04; g_rdy = 1'b1; g_clr = 1'b1;
        #1;
        check("clear_din_ready", if_a.din_ready, 1);
        check("clear_dout_valid", if_a.dout_valid, 1);
        tick();
        g_clr = 1'b0; g_vld = 1'b0; g_rdy = 1'b0;
        #1;
        check("cleared_count", a_cnt, 0);
        check("cleared_empty", a_empty, 1);
        check("cleared_dout_valid", if_a.dout_valid, 0);
        check("cleared_c_count", c_cnt, 0);
        g_vld = 1'b1; g_din = 8'h77;
        tick();
        g_vld = 1'b0;
        #1;
        check("post_clear_count", a_cnt, 1);
        check("post_clear_dout", if_a.dout, 8'h77);

        // DEPTH=1 streaming with dout_ready held high
        di = 0; ei = 0; od = 0; oe = 0; d_rdy = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            d_vld = (di < 8); d_din = 8'h80 + 8'(di);
            e_vld = (ei < 8); e_din = 8'h80 + 8'(ei);
            #1;
            if (if_d.dout_valid) begin
                check("d1_skid0_order", if_d.dout, 8'h80 + 8'(od));
                od++;
            end
            if (if_e.dout_valid) begin
                check("d1_skid1_order", if_e.dout, 8'h80 + 8'(oe));
                oe++;
            end
            acc_d = d_vld && if_d.din_ready;
            acc_e = e_vld && if_e.din_ready;
            tick();
            if (acc_d) di++;
            if (acc_e) ei++;
            if (cyc == 7) begin
                check("d1_skid0_rate", di, 8);
                check("d1_skid1_rate", ei, 4);
            end
        end
        check("d1_skid0_out", od, 8);
        check("d1_skid1_out", oe, 8);

        // Random handshakes against a queue scoreboard, DEPTH=5
        pend = 1'b0; sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            if (!pend) begin
                if (sent < 1000 && $urandom_range(3) != 0) begin
                    f_vld = 1'b1; f_din = 8'($urandom);
                end else begin
                    f_vld = 1'b0;
                end
            end
            f_rdy = ($urandom_range(2) != 0);
            #1;
            check("rand_count", f_cnt, sb.size());
            exp_rdy = (sb.size() < 5) || f_rdy;
            check("rand_din_ready", if_f.din_ready, exp_rdy);
            check("rand_dout_valid", if_f.dout_valid, sb.size() != 0);
            do_pop  = (sb.size() != 0) && f_rdy;
            do_push = f_vld && exp_rdy;
            if (do_pop) begin
                check("rand_data", if_f.dout, sb[0]);
                void'(sb.pop_front());
                rcvd++;
            end
            if (do_push) begin
                sb.push_back(f_din);
                sent++;
            end
            pend = f_vld && !do_push;
            tick();
        end
        check("rand_done", rcvd, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
